pac_move_ctrl: RTL and testbench



---
 rtl/pac_move_ctrl_pkg.sv | 30 +++
 rtl/pac_next_tile.sv | 41 ++++
 rtl/pac_move_ctrl.sv | 152 +++++++++++++++
 tb/tb_pac_move_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pac_move_ctrl_pkg.sv
// Shared constants for Pacman / ghost movement logic.
//   DIR_*        one-hot direction code {L,U,R,D} = bits 3..0, as used by the sprite mapper
//   MAP_*_DEF    default maze geometry in tiles
//   START_*_DEF  default Pacman reset tile
//   move_state_t movement sequencer states
//   onehot4()    true when exactly one of four bits is set
package pac_move_ctrl_pkg;

  localparam int MAP_W_DEF   = 28;
  localparam int MAP_H_DEF   = 31;
  localparam int START_X_DEF = 13;
  localparam int START_Y_DEF = 23;

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_Q_TURN = 2'd1,
    ST_Q_FWD  = 2'd2,
    ST_STEP   = 2'd3
  } move_state_t;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/pac_next_tile.sv
// Combinational neighbour-tile calculator.
//   x, y       current tile
//   dir        one-hot direction to look in
//   nx, ny     neighbouring tile (x wraps through the side tunnel)
//   edge_wall  1 when the neighbour would leave the maze vertically; nx/ny then
//              equal x/y. An invalid direction code is also reported as a wall
//              so nothing ever moves on a corrupt code.
module pac_next_tile
  import pac_move_ctrl_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF
) (
  input  logic [4:0] x,
  input  logic [4:0] y,
  input  logic [3:0] dir,
  output logic [4:0] nx,
  output logic [4:0] ny,
  output logic       edge_wall
);

  always_comb begin
    nx        = x;
    ny        = y;
    edge_wall = 1'b0;
    case (dir)
      DIR_L: nx = (x == 5'd0) ? 5'(MAP_W - 1) : x - 5'd1;
      DIR_R: nx = (x == 5'(MAP_W - 1)) ? 5'd0 : x + 5'd1;
      DIR_U: begin
        if (y == 5'd0) edge_wall = 1'b1;
        else           ny = y - 5'd1;
      end
      DIR_D: begin
        if (y == 5'(MAP_H - 1)) edge_wall = 1'b1;
        else                    ny = y + 5'd1;
      end
      default: edge_wall = 1'b1;
    endcase
  end

endmodule

// File: rtl/pac_move_ctrl.sv
// Pacman tile-grid movement sequencer.
//   clk, rst_n            clock, synchronous active-low reset
//   move_tick             one-cycle step opportunity (dropped unless idle)
//   key_dir               joystick request, one-hot {L,U,R,D}
//   wall_req/x/y          wall lookup request and queried tile
//   wall_ack/wall_hit     lookup completion strobe and result (1 = wall)
//   tile_x/tile_y         current tile
//   direction             facing, one-hot {L,U,R,D}
//   moving                1 while the last step attempt succeeded
//   step_done             one-cycle pulse in the first cycle the new tile is visible
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for move_tick
// ST_Q_TURN | querying the neighbour in the latched turn direction
// ST_Q_FWD  | querying the neighbour in the current facing direction
// ST_STEP   | commit the target tile
module pac_move_ctrl
  import pac_move_ctrl_pkg::*;
#(
  parameter int MAP_W   = MAP_W_DEF,
  parameter int MAP_H   = MAP_H_DEF,
  parameter int START_X = START_X_DEF,
  parameter int START_Y = START_Y_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_tick,
  input  logic [3:0] key_dir,
  output logic       wall_req,
  output logic [4:0] wall_x,
  output logic [4:0] wall_y,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [4:0] tile_x,
  output logic [4:0] tile_y,
  output logic [3:0] direction,
  output logic       moving,
  output logic       step_done
);

  move_state_t state, state_nxt;

  logic [3:0] pending;
  logic       pending_v;
  logic [3:0] turn_dir;   // snapshot of pending taken at tick, keeps the query address stable
  logic       ack_gap;    // forces wall_req low for one cycle after every accepted ack
  logic [3:0] query_dir;
  logic [4:0] nx, ny;
  logic       nbr_edge;
  logic       ack_ok;
  logic       blocked;

  // In ST_STEP the direction has already been updated by a successful turn,
  // so the same neighbour calculator yields the step target.
  assign query_dir = (state == ST_Q_TURN) ? turn_dir : direction;

  pac_next_tile #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H)
  ) u_next_tile (
    .x         (tile_x),
    .y         (tile_y),
    .dir       (query_dir),
    .nx        (nx),
    .ny        (ny),
    .edge_wall (nbr_edge)
  );

  assign ack_ok  = wall_req && wall_ack;
  // Vertical maze edge behaves like a wall hit without any lookup.
  assign blocked = nbr_edge || (ack_ok && wall_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (move_tick) begin
          if (pending_v && (pending != direction)) state_nxt = ST_Q_TURN;
          else                                     state_nxt = ST_Q_FWD;
        end
      end
      ST_Q_TURN: begin
        if (blocked)     state_nxt = ST_Q_FWD;
        else if (ack_ok) state_nxt = ST_STEP;
      end
      ST_Q_FWD: begin
        if (blocked)     state_nxt = ST_IDLE;
        else if (ack_ok) state_nxt = ST_STEP;
      end
      ST_STEP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wall_req = 1'b0;
    wall_x   = 5'd0;
    wall_y   = 5'd0;
    if (((state == ST_Q_TURN) || (state == ST_Q_FWD)) && !nbr_edge && !ack_gap) begin
      wall_req = 1'b1;
      wall_x   = nx;
      wall_y   = ny;
    end
  end

  // step_done is registered so it rises together with the new tile value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_x    <= 5'(START_X);
      tile_y    <= 5'(START_Y);
      direction <= DIR_L;
      moving    <= 1'b0;
      step_done <= 1'b0;
      pending   <= DIR_L;
      pending_v <= 1'b0;
      turn_dir  <= DIR_L;
      ack_gap   <= 1'b0;
    end else begin
      ack_gap   <= ack_ok;
      step_done <= (state == ST_STEP);

      if ((state == ST_IDLE) && move_tick) turn_dir <= pending;

      if ((state == ST_Q_TURN) && ack_ok && !wall_hit) direction <= turn_dir;

      if ((state == ST_Q_FWD) && blocked) moving <= 1'b0;

      if (state == ST_STEP) begin
        tile_x <= nx;
        tile_y <= ny;
        moving <= 1'b1;
      end

      // A fresh joystick press wins over any clearing in the same cycle.
      if (onehot4(key_dir)) begin
        pending   <= key_dir;
        pending_v <= 1'b1;
      end else if ((state == ST_Q_TURN) && ack_ok && !wall_hit) begin
        pending_v <= 1'b0;
      end else if (pending_v && (pending == direction)) begin
        pending_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pac_move_ctrl.sv
module tb_pac_move_ctrl;

  localparam int W       = 28;
  localparam int H       = 31;
  localparam int RUN_CYC = 24;

  logic       clk;
  logic       rst_n;
  logic       move_tick;
  logic [3:0] key_dir;
  logic       wall_req;
  logic [4:0] wall_x, wall_y;
  logic       wall_ack, wall_hit;
  logic [4:0] tile_x, tile_y;
  logic [3:0] direction;
  logic       moving, step_done;

  pac_move_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .move_tick (move_tick),
    .key_dir   (key_dir),
    .wall_req  (wall_req),
    .wall_x    (wall_x),
    .wall_y    (wall_y),
    .wall_ack  (wall_ack),
    .wall_hit  (wall_hit),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .direction (direction),
    .moving    (moving),
    .step_done (step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- wall lookup responder ----------------
  bit wall_map [0:31][0:31];
  bit hit_q[$];
  int obs_q[$];
  int ack_lat  = 0;
  int spur_pct = 0;
  bit busy     = 1'b0;
  int cnt      = 0;
  int held     = 0;

  always @(negedge clk) begin
    if (!wall_req) begin
      busy     = 1'b0;
      wall_ack = (spur_pct > 0) && (int'($urandom_range(0, 99)) < spur_pct);
      wall_hit = 1'($urandom);
    end else begin
      if (!busy) begin
        busy = 1'b1;
        cnt  = ack_lat;
        held = int'(wall_x) * 32 + int'(wall_y);
      end else begin
        chk("addr_stable", int'(wall_x) * 32 + int'(wall_y), held);
      end
      if (cnt == 0) begin
        wall_ack = 1'b1;
        if (hit_q.size() > 0) wall_hit = hit_q.pop_front();
        else                  wall_hit = wall_map[wall_x][wall_y];
        obs_q.push_back(held);
        busy = 1'b0;
      end else begin
        wall_ack = 1'b0;
        wall_hit = 1'($urandom);
        cnt--;
      end
    end
  end

  // ---------------- reference model ----------------
  int         m_x, m_y;
  logic [3:0] m_dir, m_pend;
  bit         m_pv, m_mov;
  int         exp_q[$];
  int         exp_done, exp_lat;

  function automatic void nbr(input int x, input int y, input logic [3:0] d,
                              output int nx, output int ny, output bit e);
    nx = x; ny = y; e = 1'b0;
    case (d)
      4'b1000: nx = (x + W - 1) % W;
      4'b0010: nx = (x + 1) % W;
      4'b0100: if (y == 0) e = 1'b1; else ny = y - 1;
      4'b0001: if (y == H - 1) e = 1'b1; else ny = y + 1;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 13; m_y = 23; m_dir = 4'b1000; m_pend = 4'b1000; m_pv = 1'b0; m_mov = 1'b0;
  endtask

  task automatic model_key(input logic [3:0] k);
    if ($countones(k) == 1) begin
      m_pend = k;
      m_pv   = 1'b1;
    end
  endtask

  // Expected queries, outcome and tick-to-step_done latency of one move attempt.
  task automatic model_tick(input int lat);
    int nx, ny;
    bit e;
    exp_q.delete();
    exp_done = 0;
    exp_lat  = 1;
    if (m_pv && (m_pend != m_dir)) begin
      nbr(m_x, m_y, m_pend, nx, ny, e);
      if (e) exp_lat += 1;
      else begin
        exp_q.push_back(nx * 32 + ny);
        exp_lat += lat + 1;
        if (!wall_map[nx][ny]) begin
          m_dir = m_pend; m_pv = 1'b0; m_x = nx; m_y = ny; m_mov = 1'b1;
          exp_done = 1; exp_lat += 1;
          return;
        end
        exp_lat += 1;  // request drops for a cycle before the forward query
      end
    end else begin
      m_pv = 1'b0;
    end
    nbr(m_x, m_y, m_dir, nx, ny, e);
    if (e) m_mov = 1'b0;
    else begin
      exp_q.push_back(nx * 32 + ny);
      exp_lat += lat + 1;
      if (wall_map[nx][ny]) m_mov = 1'b0;
      else begin
        m_x = nx; m_y = ny; m_mov = 1'b1;
        exp_done = 1; exp_lat += 1;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  int n_done, first_done, req_cyc;

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [3:0] k);
    key_dir = k;
    @(posedge clk); #1;
    key_dir = 4'b0000;
    model_key(k);
  endtask

  task automatic run_tick(input int lat, input bit xtick);
    ack_lat = lat;
    obs_q.delete();
    n_done = 0; first_done = -1; req_cyc = 0;
    move_tick = 1'b1;
    for (int i = 0; i < RUN_CYC; i++) begin
      @(negedge clk);
      if (step_done) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
      if (wall_req) req_cyc++;
      @(posedge clk); #1;
      move_tick = (i == 0) ? xtick : 1'b0;
    end
  endtask

  task automatic move(input int lat, input bit xtick);
    model_tick(lat);
    run_tick(lat, xtick);
    chk("done_cnt", n_done, exp_done);
    if (exp_done != 0) chk("done_lat", first_done, exp_lat);
    chk("tile_x", tile_x, m_x);
    chk("tile_y", tile_y, m_y);
    chk("direction", direction, m_dir);
    chk("moving", moving, m_mov);
    chk("req_idle", wall_req, 0);
    chk("n_query", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk("query_addr", obs_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic [3:0] key;
    int         lat;
    bit         h0;
    bit         h1;
    int         ex;
    int         ey;
    logic [3:0] edir;
    bit         emov;
    int         enq;
    int         eq0;
    int         edone;
  } vec_t;

  vec_t tbl [9];

  initial begin
    rst_n = 1'b0; move_tick = 1'b0; key_dir = 4'b0000;
    wall_ack = 1'b0; wall_hit = 1'b0;
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++) wall_map[x][y] = 1'b0;

    tbl[0] = '{4'b0000, 0, 1'b0, 1'b0, 12, 23, 4'b1000, 1'b1, 1, 12*32+23, 1};
    tbl[1] = '{4'b0100, 1, 1'b0, 1'b0, 12, 22, 4'b0100, 1'b1, 1, 12*32+22, 1};
    tbl[2] = '{4'b0010, 2, 1'b1, 1'b1, 12, 22, 4'b0100, 1'b0, 2, 13*32+22, 0};
    tbl[3] = '{4'b0000, 0, 1'b0, 1'b0, 13, 22, 4'b0010, 1'b1, 1, 13*32+22, 1};
    tbl[4] = '{4'b1100, 3, 1'b0, 1'b0, 14, 22, 4'b0010, 1'b1, 1, 14*32+22, 1};
    tbl[5] = '{4'b0010, 0, 1'b1, 1'b0, 14, 22, 4'b0010, 1'b0, 1, 15*32+22, 0};
    tbl[6] = '{4'b0001, 1, 1'b1, 1'b0, 15, 22, 4'b0010, 1'b1, 2, 14*32+23, 1};
    tbl[7] = '{4'b0000, 2, 1'b0, 1'b0, 15, 23, 4'b0001, 1'b1, 1, 15*32+23, 1};
    tbl[8] = '{4'b0000, 3, 1'b0, 1'b0, 15, 24, 4'b0001, 1'b1, 1, 15*32+24, 1};

    // Reset state
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rst_tile_x", tile_x, 13);
    chk("rst_tile_y", tile_y, 23);
    chk("rst_dir", direction, 4'b1000);
    chk("rst_moving", moving, 0);
    chk("rst_req", wall_req, 0);
    chk("rst_wall_x", wall_x, 0);
    chk("rst_wall_y", wall_y, 0);
    chk("rst_step_done", step_done, 0);
    @(posedge clk); #1;

    // Zero-wait forward step: step_done exactly 3 cycles after the tick
    run_tick(0, 1'b0);
    chk("fwd_n_query", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("fwd_query", obs_q[0], 12*32+23);
    chk("fwd_done_lat", first_done, 3);
    chk("fwd_done_cnt", n_done, 1);
    chk("fwd_tile_x", tile_x, 12);
    chk("fwd_moving", moving, 1);

    // Table-driven sequence with forced lookup results
    do_reset();
    for (int r = 0; r < 9; r++) begin
      hit_q.delete();
      hit_q.push_back(tbl[r].h0);
      hit_q.push_back(tbl[r].h1);
      if (tbl[r].key != 4'b0000) press(tbl[r].key);
      run_tick(tbl[r].lat, 1'b0);
      chk("tbl_tile_x", tile_x, tbl[r].ex);
      chk("tbl_tile_y", tile_y, tbl[r].ey);
      chk("tbl_dir", direction, tbl[r].edir);
      chk("tbl_moving", moving, tbl[r].emov);
      chk("tbl_n_query", obs_q.size(), tbl[r].enq);
      if (obs_q.size() > 0) chk("tbl_query0", obs_q[0], tbl[r].eq0);
      chk("tbl_done", n_done, tbl[r].edone);
    end
    hit_q.delete();

    // Reset in the middle of a handshake, then late acks must be ignored
    do_reset();
    ack_lat = 10;
    move_tick = 1'b1;
    @(posedge clk); #1;
    move_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_req_before", wall_req, 1);
    rst_n = 1'b0;
    spur_pct = 100;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_req", wall_req, 0);
      chk("midrst_step_done", step_done, 0);
    end
    spur_pct = 0;
    @(posedge clk); #1;
    chk("midrst_tile_x", tile_x, 13);
    chk("midrst_tile_y", tile_y, 23);
    chk("midrst_dir", direction, 4'b1000);

    // Open maze walks: tunnel wrap both ways, edge walls, dropped ticks
    do_reset();
    model_reset();
    press(4'b0100); move(0, 1'b0);
    repeat (8) move(1, 1'b0);
    press(4'b1000); move(0, 1'b0);
    repeat (12) move(0, 1'b0);
    chk("walk_x0", tile_x, 0);
    chk("walk_y14", tile_y, 14);
    move(0, 1'b0);
    chk("wrap_left_x", tile_x, 27);
    if (obs_q.size() > 0) chk("wrap_left_query", obs_q[0], 27*32+14);
    press(4'b0010); move(0, 1'b0);
    chk("wrap_right_x", tile_x, 0);
    press(4'b0100); move(0, 1'b0);
    repeat (13) move(0, 1'b0);
    move(2, 1'b0);
    chk("edge_up_req", req_cyc, 0);
    chk("edge_up_moving", moving, 0);
    press(4'b1000); move(0, 1'b0);
    press(4'b0100); move(1, 1'b0);
    chk("edge_turn_x", tile_x, 26);
    press(4'b0001); move(0, 1'b0);
    repeat (29) move(0, 1'b0);
    move(0, 1'b0);
    chk("edge_down_req", req_cyc, 0);
    chk("edge_down_y", tile_y, 30);
    press(4'b1000); move(5, 1'b1);
    move(5, 1'b1);
    chk("drop_tick_done", n_done, 1);

    // Randomized walls, keys, latencies, spurious acks and extra ticks
    do_reset();
    model_reset();
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++) wall_map[x][y] = (int'($urandom_range(0, 99)) < 25);
    spur_pct = 20;
    for (int t = 0; t < 200; t++) begin
      int nk;
      nk = int'($urandom_range(0, 2));
      for (int k = 0; k < nk; k++) begin
        logic [3:0] kv;
        case ($urandom_range(0, 3))
          0, 1:    kv = 4'b0001 << $urandom_range(0, 3);
          2:       kv = 4'b0000;
          default: kv = 4'($urandom);
        endcase
        press(kv);
      end
      move(int'($urandom_range(0, 4)), 1'($urandom));
    end
    spur_pct = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
